// File: rtl/mem_access_unit.sv
// RISC-V MEM-stage load/store unit. Loads and SW complete in one cycle, and a load result is registered for the next cycle.
// SB/SH use read-modify-write and stall upstream for one cycle; misaligned or illegal requests pulse fault with no memory strobe.
module mem_access_unit #(
  parameter bit RMW_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_read,
  input  logic        req_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        fault,
  output logic [31:0] mem_addr,
  output logic        mem_MemRead,
  output logic        mem_MemWrite,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] RMW_WR = 1'b1;

  logic [0:0]  state;
  logic [31:0] merge_q;
  logic [31:0] addr_q;

  logic        is_load, is_store, both_set, f3_ok, misal, ok, in_idle;
  logic        go_load, go_sw, go_rmw, go_fault;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] ext_data, merged;

  always_comb begin
    in_idle  = (state == IDLE);
    is_load  = req_valid && req_read && !req_write;
    is_store = req_valid && req_write && !req_read;
    both_set = req_valid && req_read && req_write;
    f3_ok    = 1'b0;
    if (is_load)
      f3_ok = funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    if (is_store)
      f3_ok = (funct3 == 3'b010) || (RMW_EN && (funct3 == 3'b000 || funct3 == 3'b001));
    misal    = ((funct3[1:0] == 2'b01) && addr[0]) ||
               ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
    ok       = f3_ok && !misal;
    go_load  = in_idle && is_load && ok;
    go_sw    = in_idle && is_store && ok && (funct3 == 3'b010);
    go_rmw   = in_idle && is_store && ok && (funct3 != 3'b010);
    go_fault = in_idle && (both_set || ((is_load || is_store) && !ok));
  end

  always_comb begin
    lane_b = mem_rdata[{addr[1:0], 3'b000} +: 8];
    lane_h = addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (funct3)
      3'b000:  ext_data = {{24{lane_b[7]}}, lane_b};
      3'b100:  ext_data = {24'h0, lane_b};
      3'b001:  ext_data = {{16{lane_h[15]}}, lane_h};
      3'b101:  ext_data = {16'h0, lane_h};
      default: ext_data = mem_rdata;
    endcase
    merged = mem_rdata;
    if (funct3[0])
      merged[{addr[1], 4'b0000} +: 16] = wdata[15:0];
    else
      merged[{addr[1:0], 3'b000} +: 8] = wdata[7:0];
  end

  // Combinational outputs are gated by rst_n so reset silences the memory port at once.
  always_comb begin
    stall        = rst_n && go_rmw;
    mem_MemRead  = rst_n && (go_load || go_rmw);
    mem_MemWrite = rst_n && (go_sw || (state == RMW_WR));
    mem_addr     = 32'h0;
    mem_wdata    = 32'h0;
    if (rst_n) begin
      mem_addr  = (state == RMW_WR) ? addr_q : {2'b00, addr[31:2]};
      if (state == RMW_WR)
        mem_wdata = merge_q;
      else if (go_sw)
        mem_wdata = wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      merge_q    <= 32'h0;
      addr_q     <= 32'h0;
      load_data  <= 32'h0;
      load_valid <= 1'b0;
      fault      <= 1'b0;
    end else begin
      load_valid <= go_load;
      fault      <= go_fault;
      if (go_load)
        load_data <= ext_data;
      case (state)
        IDLE: begin
          if (go_rmw) begin
            merge_q <= merged;
            addr_q  <= {2'b00, addr[31:2]};
            state   <= RMW_WR;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit against a 16-word behavioural data memory.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_read = 1'b0, req_write = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] addr = 32'h0, wdata = 32'h0;
  logic        stall, load_valid, fault, mem_MemRead, mem_MemWrite;
  logic [31:0] load_data, mem_addr, mem_wdata, mem_rdata;
  logic [31:0] mem [0:15];

  int checks = 0;
  int errors = 0;

  mem_access_unit #(.RMW_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_read(req_read),
    .req_write(req_write), .funct3(funct3), .addr(addr), .wdata(wdata),
    .stall(stall), .load_data(load_data), .load_valid(load_valid), .fault(fault),
    .mem_addr(mem_addr), .mem_MemRead(mem_MemRead), .mem_MemWrite(mem_MemWrite),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[3:0]];

  always @(posedge clk) begin
    check("strobe_excl", {31'h0, mem_MemRead & mem_MemWrite}, 32'h0);
    if (mem_MemWrite)
      mem[mem_addr[3:0]] <= mem_wdata;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic r, input logic w,
                       input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    req_valid = v; req_read = r; req_write = w; funct3 = f3; addr = a; wdata = d;
    #1;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    mem[0] = 32'h0000_0011;
    mem[1] = 32'h0000_0009;

    // Request applied while in reset must be ignored
    drive(1, 1, 0, 3'b000, 32'h0, 32'h0);
    check("rst_memread", {31'h0, mem_MemRead}, 32'h0);
    check("rst_stall", {31'h0, stall}, 32'h0);
    tick;
    check("rst_load_data", load_data, 32'h0);
    check("rst_load_valid", {31'h0, load_valid}, 32'h0);
    check("rst_fault", {31'h0, fault}, 32'h0);

    // LB addr 0, accepted on the first edge after reset release
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("lb0_memread", {31'h0, mem_MemRead}, 32'h1);
    check("lb0_stall", {31'h0, stall}, 32'h0);
    tick;
    check("lb0_data", load_data, 32'h0000_0011);
    check("lb0_valid", {31'h0, load_valid}, 32'h1);
    drive(0, 0, 0, 3'b000, 32'h0, 32'h0);
    check("idle_strobes", {30'h0, mem_MemRead, mem_MemWrite}, 32'h0);
    tick;
    check("lb0_valid_pulse", {31'h0, load_valid}, 32'h0);
    check("lb0_hold", load_data, 32'h0000_0011);

    // SB addr 1: read phase then write phase, request held through RMW_WR
    drive(1, 0, 1, 3'b000, 32'h1, 32'h80);
    check("sb_stall", {31'h0, stall}, 32'h1);
    check("sb_memread", {31'h0, mem_MemRead}, 32'h1);
    tick;
    @(negedge clk);
    #1;
    check("sb_wr_stall", {31'h0, stall}, 32'h0);
    check("sb_memwrite", {31'h0, mem_MemWrite}, 32'h1);
    check("sb_wdata", mem_wdata, 32'h0000_8011);
    check("sb_addr", mem_addr, 32'h0);
    tick;
    check("sb_mem0", mem[0], 32'h0000_8011);
    drive(1, 1, 0, 3'b000, 32'h1, 32'h0);
    tick;
    check("lb1_data", load_data, 32'hFFFF_FF80);
    drive(1, 1, 0, 3'b101, 32'h0, 32'h0);
    tick;
    check("lhu0_data", load_data, 32'h0000_8011);

    // Misaligned SH and LW
    drive(1, 0, 1, 3'b001, 32'h1, 32'h1234);
    check("sh_mis_strobes", {30'h0, mem_MemRead, mem_MemWrite}, 32'h0);
    tick;
    check("sh_mis_fault", {31'h0, fault}, 32'h1);
    check("sh_mis_valid", {31'h0, load_valid}, 32'h0);
    drive(0, 0, 0, 3'b000, 32'h0, 32'h0);
    tick;
    check("fault_pulse", {31'h0, fault}, 32'h0);
    drive(1, 1, 0, 3'b010, 32'h6, 32'h0);
    check("lw_mis_strobes", {30'h0, mem_MemRead, mem_MemWrite}, 32'h0);
    tick;
    check("lw_mis_fault", {31'h0, fault}, 32'h1);
    check("lw_mis_hold", load_data, 32'h0000_8011);
    check("mis_mem0", mem[0], 32'h0000_8011);

    // Illegal encodings
    drive(1, 1, 1, 3'b010, 32'h0, 32'h0);
    check("both_strobes", {30'h0, mem_MemRead, mem_MemWrite}, 32'h0);
    tick;
    check("both_fault", {31'h0, fault}, 32'h1);
    drive(1, 1, 0, 3'b011, 32'h0, 32'h0);
    tick;
    check("ld011_fault", {31'h0, fault}, 32'h1);

    // SW then LH upper half
    drive(1, 0, 1, 3'b010, 32'h8, 32'hDEAD_BEEF);
    check("sw_memwrite", {31'h0, mem_MemWrite}, 32'h1);
    check("sw_wdata", mem_wdata, 32'hDEAD_BEEF);
    check("sw_addr", mem_addr, 32'h2);
    check("sw_stall", {31'h0, stall}, 32'h0);
    tick;
    check("sw_fault_clr", {31'h0, fault}, 32'h0);
    check("sw_mem2", mem[2], 32'hDEAD_BEEF);
    drive(1, 1, 0, 3'b001, 32'hA, 32'h0);
    tick;
    check("lh_a_data", load_data, 32'hFFFF_DEAD);

    // Reset asserted during RMW_WR of SB addr 4
    drive(1, 0, 1, 3'b000, 32'h4, 32'hFF);
    check("sb4_stall", {31'h0, stall}, 32'h1);
    tick;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_memwrite", {31'h0, mem_MemWrite}, 32'h0);
    check("abort_stall", {31'h0, stall}, 32'h0);
    check("abort_addr", mem_addr, 32'h0);
    check("abort_wdata", mem_wdata, 32'h0);
    check("abort_load_data", load_data, 32'h0);
    check("abort_valid_fault", {30'h0, load_valid, fault}, 32'h0);
    tick;
    check("abort_mem1", mem[1], 32'h0000_0009);

    // First edge after release accepts LW addr 4
    drive(1, 1, 0, 3'b010, 32'h4, 32'h0);
    rst_n = 1'b1;
    tick;
    check("post_rst_lw", load_data, 32'h0000_0009);
    check("post_rst_valid", {31'h0, load_valid}, 32'h1);
    drive(0, 0, 0, 3'b000, 32'h0, 32'h0);
    tick;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter RMW_EN, default 1: 1 = sub-word stores via read-modify-write; 0 = SB/SH flagged as fault, no write.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port req_valid  input  1  MEM-stage request present.
REQ-005 SHALL have port req_read  input  1  load request.
REQ-006 SHALL have port req_write  input  1  store request.
REQ-007 SHALL have port funct3  input  3  RISC-V width/sign code (000 B, 001 H, 010 W, 100 BU, 101 HU).
REQ-008 SHALL have port addr  input  32  byte address.
REQ-009 SHALL have port wdata  input  32  store data, LSB-aligned.
REQ-010 SHALL have port stall  output  1  hold the MEM stage and upstream this cycle.
REQ-011 SHALL have port load_data  output  32  registered, extended load result.
REQ-012 SHALL have port load_valid  output  1  one-cycle pulse; load_data is valid.
REQ-013 SHALL have port fault  output  1  one-cycle registered pulse; misaligned or illegal access.
REQ-014 SHALL have port mem_addr  output  32  word index to data memory, {2'b00, addr[31:2]}.
REQ-015 SHALL have ports mem_MemRead and mem_MemWrite  output  1 each  data-memory strobes.
REQ-016 SHALL have ports mem_wdata  output  32 and mem_rdata  input  32  data-memory write and combinational read data.

Function
REQ-017 SHALL implement FSM states IDLE and RMW_WR.
REQ-018 SHALL accept a request in IDLE when req_valid=1 and exactly one of req_read/req_write is 1.
REQ-019 SHALL treat both-set, unsupported funct3 (loads 011/110/111; stores other than 000/001/010), or RMW_EN=0 sub-word stores as illegal: no memory strobe, fault pulsed next cycle.
REQ-020 SHALL treat halfword with addr[0]=1 and word with addr[1:0]!=0 as misaligned: no memory strobe, fault pulsed next cycle.
REQ-021 Load (IDLE) SHALL drive mem_MemRead=1, pick byte addr[1:0] or halfword addr[1], sign- or zero-extend per funct3, and register the result into load_data with load_valid=1 on the next cycle; stall=0.
REQ-022 SW (IDLE) SHALL drive mem_MemWrite=1, mem_wdata=wdata in the same cycle; stall=0; no state change.
REQ-023 SB/SH (IDLE) SHALL drive mem_MemRead=1, assert stall=1, capture mem_rdata with wdata[7:0] or wdata[15:0] merged into lane addr[1:0] or addr[1], latch mem_addr, and go to RMW_WR.
REQ-024 In RMW_WR, SHALL drive mem_MemWrite=1 with the latched address and merged word, stall=0, and return to IDLE.
REQ-025 SHALL ignore request inputs in RMW_WR, because the held request is the same store.
REQ-026 SHALL hold load_data between loads; load_valid and fault SHALL each be high for exactly one cycle per event.
REQ-027 mem_MemRead and mem_MemWrite SHALL never both be 1 in one cycle and SHALL be 0 when no access is in progress.
REQ-028 Back-to-back requests SHALL be accepted every cycle except the cycle after an SB/SH accept.

Reset
REQ-029 rst_n=0 SHALL immediately force state IDLE, stall=0, load_valid=0, fault=0, load_data=0, mem strobes=0, merge and address registers=0.
REQ-030 Reset asserted in RMW_WR SHALL abort the write; memory stays unmodified.
REQ-031 After rst_n rises, the first rising clk edge SHALL accept a request normally.

Verification
REQ-032 Memory word0=0x00000011: LB addr=0x0 -> next cycle load_data=0x00000011, load_valid=1, stall=0 throughout.
REQ-033 SB addr=0x1 wdata=0x80 -> cycle 1 stall=1, MemRead=1; cycle 2 MemWrite=1, mem_wdata=0x00008011; then LB addr=0x1 -> 0xFFFFFF80 and LHU addr=0x0 -> 0x00008011.
REQ-034 SH addr=0x1 and LW addr=0x6 -> no strobes, fault=1 for one cycle, memory and load_data unchanged.
REQ-035 SW addr=0x8 wdata=0xDEADBEEF then LH addr=0xA -> word2=0xDEADBEEF, load_data=0xFFFFDEAD.
REQ-036 rst_n low during RMW_WR of SB addr=0x4 wdata=0xFF -> no MemWrite, word1 remains 0x00000009, all outputs 0.
